// File: rtl/mult_div_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
package mult_div_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_CNT_W  = 6;
  localparam int unsigned ITERATIONS = DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/data bundle between the main control FSM and mult_div_unit.
// MULT_DIV_UNSIGNED_EN adds the is_unsigned request qualifier.
interface mult_div_unit_if import mult_div_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

`ifdef MULT_DIV_UNSIGNED_EN
  logic             is_unsigned;

  modport master (
    output mult_start, div_start, input_a, input_b, is_unsigned,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, input_a, input_b, is_unsigned,
    output hi_out, lo_out, busy, done, div_zero
  );
`else
  modport master (
    output mult_start, div_start, input_a, input_b,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, input_a, input_b,
    output hi_out, lo_out, busy, done, div_zero
  );
`endif

endinterface

// File: rtl/mult_div_unit_div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           borrow;

  // The remainder is always below the divisor, so it fits WIDTH bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    borrow   = shifted < divisor;
    rem_next = borrow ? shifted[WIDTH-1:0] : WIDTH'(shifted - divisor);
    quo_next = {quo[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) with HI/LO.
// MULT_DIV_UNSIGNED_EN adds multu/divu support via bus.is_unsigned.
module mult_div_unit import mult_div_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

`ifdef MULT_DIV_UNSIGNED_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    m_reg;
  logic [2*MW:0]    acc;
  logic [WIDTH-1:0] rem_reg, quo_reg;
  logic [WIDTH:0]   dvs_reg;
  logic             neg_q, neg_r, dz_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic             uns_in;
  logic [MW-1:0]    a_ext, b_ext;
  logic [MW:0]      booth_sum;
  logic [2*MW:0]    acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             last_iter;

`ifdef MULT_DIV_UNSIGNED_EN
  logic             uns;

  assign uns_in = bus.is_unsigned;
  assign a_ext  = {~uns_in & bus.input_a[WIDTH-1], bus.input_a};
  assign b_ext  = {~uns_in & bus.input_b[WIDTH-1], bus.input_b};
  // Signed ops keep WIDTH iterations on the wider datapath, so the product sits one bit higher.
  assign prod      = uns ? acc_next[2*WIDTH:1] : acc_next[2*WIDTH+1:2];
  assign last_iter = (uns && state == MULT) ? (cnt == CNT_W'(WIDTH))
                                            : (cnt == CNT_W'(WIDTH - 1));
`else
  assign uns_in    = 1'b0;
  assign a_ext     = bus.input_a;
  assign b_ext     = bus.input_b;
  assign prod      = acc_next[2*WIDTH:1];
  assign last_iter = cnt == CNT_W'(WIDTH - 1);
`endif

  // Booth step: A +/- M with a guard bit, then arithmetic right shift of {A, Q, q_-1}.
  always_comb begin
    booth_sum = {acc[2*MW], acc[2*MW:MW+1]};
    unique case (acc[1:0])
      2'b01:   booth_sum = {acc[2*MW], acc[2*MW:MW+1]} + {m_reg[MW-1], m_reg};
      2'b10:   booth_sum = {acc[2*MW], acc[2*MW:MW+1]} - {m_reg[MW-1], m_reg};
      default: booth_sum = {acc[2*MW], acc[2*MW:MW+1]};
    endcase
    acc_next = {booth_sum, acc[MW:1]};
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvs_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fix = neg_q ? -quo_next : quo_next;
  assign r_fix = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.div_zero = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mult_start)     state_next = MULT;
        else if (bus.div_start) state_next = (bus.input_b == '0) ? FINISH : DIV;
      end
      MULT, DIV: begin
        bus.busy = 1'b1;
        if (last_iter) state_next = FINISH;
      end
      FINISH: begin
        bus.done     = 1'b1;
        bus.div_zero = dz_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      m_reg   <= '0;
      acc     <= '0;
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_reg  <= 1'b0;
      hi_reg  <= '0;
      lo_reg  <= '0;
`ifdef MULT_DIV_UNSIGNED_EN
      uns     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mult_start || bus.div_start) begin
            cnt    <= '0;
            dz_reg <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
            uns    <= uns_in;
`endif
            if (bus.mult_start) begin
              m_reg <= a_ext;
              acc   <= {{MW{1'b0}}, b_ext, 1'b0};
            end else begin
              neg_q   <= ~uns_in & (bus.input_a[WIDTH-1] ^ bus.input_b[WIDTH-1]);
              neg_r   <= ~uns_in & bus.input_a[WIDTH-1];
              quo_reg <= (~uns_in & bus.input_a[WIDTH-1]) ? -bus.input_a : bus.input_a;
              rem_reg <= '0;
              dvs_reg <= {1'b0, (~uns_in & bus.input_b[WIDTH-1]) ? -bus.input_b : bus.input_b};
              dz_reg  <= bus.input_b == '0;
            end
          end
        end
        MULT: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi_reg <= prod[2*WIDTH-1:WIDTH];
            lo_reg <= prod[WIDTH-1:0];
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            hi_reg <= r_fix;
            lo_reg <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out = hi_reg;
  assign bus.lo_out = lo_reg;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle signed multiply/divide engine for the multicycle MIPS datapath; executes mult/div and owns the HI/LO registers.
- Sits directly upstream of the register-file write-data mux: hi_out/lo_out are two of that mux's data inputs (selected for mfhi/mflo).
- Controlled by the main control FSM through a start/done handshake; the control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mult_start  in  1  one-cycle request for a signed multiply; ignored unless idle.
- div_start  in  1  one-cycle request for a signed divide; ignored unless idle.
- input_a  in  WIDTH  rs operand (multiplicand/dividend); sampled only on an accepted start.
- input_b  in  WIDTH  rt operand (multiplier/divisor); sampled only on an accepted start.
- hi_out  out  WIDTH  HI register: product upper half or remainder.
- lo_out  out  WIDTH  LO register: product lower half or quotient.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- div_zero  out  1  one-cycle pulse, coincident with done, on a divide by zero.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; hi_out=0, lo_out=0, busy=0, done=0, div_zero=0; counter and operand registers are cleared.
- States: IDLE, MULT, DIV, FINISH.
- Start acceptance:
  - A start is accepted only in IDLE.
  - If mult_start and div_start are both high, mult_start wins.
  - Starts seen in any other state are ignored with no side effects.
- Accepted start at edge E0: operands are latched, counter=0, state goes to MULT or DIV.
- Divide by zero: if div_start is accepted with input_b==0, the unit goes IDLE->FINISH at E0 instead. In FINISH: div_zero=1, done=1, HI/LO unchanged.
- MULT: radix-2 Booth algorithm.
  - Registers: 2*WIDTH+1-bit accumulator {A, Q, q_-1}.
  - Each edge does one add/sub-of-M step followed by an arithmetic right shift.
  - Exactly WIDTH iterations.
- DIV: restoring division on magnitudes.
  - |a| and |b| are computed at E0.
  - Each edge performs shift, trial subtract and restore.
  - Exactly WIDTH iterations.
  - Sign fix at completion: quotient is negated if the signs of a and b differ; remainder takes the sign of the dividend. Quotient truncates toward zero (MIPS semantics).
- The iteration at edge E_k has counter==k-1. At E_WIDTH (counter==WIDTH-1) the state moves to FINISH and HI/LO are loaded on that same edge.
- FINISH: done=1 for exactly one cycle, then IDLE. For WIDTH=32, done is high in the cycle following E32.
- busy is high in MULT and DIV and low in IDLE and FINISH. A new start is accepted only in IDLE, i.e. no earlier than the cycle after done.
- HI/LO hold their value between operations and are never partially updated; intermediate values stay in internal registers.
- The most-negative operand is legal:
  - 0x80000000 / -1 gives LO=0x80000000, HI=0 (wrap, no flag).
  - Magnitude arithmetic uses WIDTH+1 bits.
- Reset asserted mid-operation aborts the operation immediately and applies the reset values above.

Optional Feature:
- Macro MULT_DIV_UNSIGNED_EN.
- Defined: adds input port is_unsigned (1 bit), sampled with the start.
  - When is_unsigned=1, operands are zero-extended and no sign fix is applied (multu/divu).
  - Multiply uses a WIDTH+1-bit zero-extended Booth datapath with WIDTH+1 iterations, so done comes one cycle later.
- Undefined: no port; all operations are signed.

Decomposition:
- Package mult_div_pkg:
  - WIDTH and CNT_W defaults.
  - State enum md_state_t {IDLE, MULT, DIV, FINISH}.
  - Localparam ITERATIONS.
- Sub-module div_restore_step: combinational single restoring iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder and next quotient.
  - Instantiated once by the sequential top.

Test Plan:
- mult 7 × -3 (0x00000007, 0xFFFFFFFD) -> busy for 32 cycles; done in the cycle after E32; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- mult 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0x00000000; mult 0 × 0x12345678 -> HI=LO=0.
- div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- After a known HI/LO result, div 5 / 0 -> done and div_zero high together in the cycle after E0; HI/LO unchanged; busy never asserted.
- mult_start and div_start together with 6, 4 -> multiply performed, LO=24. mult_start pulsed at cycle 5 while busy -> ignored, result unchanged.
- reset low at cycle 10 of a divide -> all outputs 0 immediately; mult 3 × 3 after release gives LO=9. With MULT_DIV_UNSIGNED_EN: divu 0xFFFFFFFF / 2 -> LO=0x7FFFFFFF, HI=1.
